bus_arbiter: RTL

Parametrised multi-master arbiter in front of the MMU. It merges N bus masters (CPU, OAM DMA, HDMA, debug port) onto the single master-side bus that the MMU routes to peripherals. Arbitration is round-robin or fixed-priority, with per-master bus lock for burst/DMA ownership. It issues registered downstream transactions and returns registered read data with a per-master valid strobe.

---
 rtl/bus_pkg.sv | 13 +
 rtl/rr_select.sv | 31 +++
 rtl/bus_arbiter.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// Shared types and constants for the multi-master bus arbiter.
// Master indices name the fixed slots: 0 is the CPU, 1 is the OAM/HDMA engine.
package bus_pkg;

    typedef enum logic {
        IDLE,
        ISSUE
    } bus_state_t;

    localparam int unsigned MASTER_CPU = 0;
    localparam int unsigned MASTER_DMA = 1;

endpackage

// File: rtl/rr_select.sv
// Combinational picker: first set request bit at or after ptr, wrapping at N-1.
// A pointer tied to zero turns it into a lowest-index-wins priority encoder.
module rr_select #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] idx,
    output logic                 hit
);
    localparam int unsigned IW = $clog2(N);

    int unsigned cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        hit  = 1'b0;
        cand = 0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = (32'(ptr) + k) % N;
            if (!hit && req[cand[IW-1:0]]) begin
                hit                = 1'b1;
                gnt[cand[IW-1:0]]  = 1'b1;
                idx                = cand[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// N-master arbiter: one registered downstream transaction every two cycles, round-robin or
// fixed priority, with lock so a DMA master can keep the bus across a burst.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned FIXED_PRIO  = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0]  m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]  m_wdata,
    input  logic [NUM_MASTERS-1:0]         m_read_en,
    input  logic [NUM_MASTERS-1:0]         m_write_en,
    input  logic [NUM_MASTERS-1:0]         m_lock,
    output logic [NUM_MASTERS-1:0]         m_ack,
    output logic [DATA_W-1:0]              m_rdata,
    output logic [NUM_MASTERS-1:0]         m_rvalid,
    output logic [ADDR_W-1:0]              s_addr,
    output logic [DATA_W-1:0]              s_wdata,
    output logic                           s_read_en,
    output logic                           s_write_en,
    input  logic [DATA_W-1:0]              s_rdata,
    output logic [$clog2(NUM_MASTERS)-1:0] grant_idx,
    output logic                           locked
);
    localparam int unsigned IW = $clog2(NUM_MASTERS);

    bus_state_t             state_q, state_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]          grant_idx_q, grant_idx_d;
    logic                   locked_q, locked_d;
    logic [ADDR_W-1:0]      s_addr_q, s_addr_d;
    logic [DATA_W-1:0]      s_wdata_q, s_wdata_d;
    logic                   s_read_en_q, s_read_en_d;
    logic                   s_write_en_q, s_write_en_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;

    logic [NUM_MASTERS-1:0] owner_mask, req, elig, sel_gnt;
    logic [IW-1:0]          sel_ptr, sel_idx;
    logic                   sel_hit, eff_lock;

    assign owner_mask = NUM_MASTERS'(1) << grant_idx_q;
    assign req        = m_read_en | m_write_en;
    // An owner dropping m_lock in IDLE releases the bus for this same arbitration.
    assign eff_lock   = locked_q & m_lock[grant_idx_q];
    assign elig       = eff_lock ? (req & owner_mask) : req;
    assign sel_ptr    = (FIXED_PRIO != 0) ? '0 : rr_ptr_q;

    rr_select #(
        .N(NUM_MASTERS)
    ) u_rr_select (
        .req(elig),
        .ptr(sel_ptr),
        .gnt(sel_gnt),
        .idx(sel_idx),
        .hit(sel_hit)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            grant_idx_q  <= IW'(MASTER_CPU);
            locked_q     <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_read_en_q  <= 1'b0;
            s_write_en_q <= 1'b0;
            rdata_q      <= '0;
            rvalid_q     <= '0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            grant_idx_q  <= grant_idx_d;
            locked_q     <= locked_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_read_en_q  <= s_read_en_d;
            s_write_en_q <= s_write_en_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_idx_d  = grant_idx_q;
        locked_d     = locked_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_read_en_d  = 1'b0;
        s_write_en_d = 1'b0;
        rdata_d      = rdata_q;
        rvalid_d     = '0;
        unique case (state_q)
            IDLE: begin
                locked_d = eff_lock;
                if (sel_hit) begin
                    state_d      = ISSUE;
                    grant_idx_d  = sel_idx;
                    s_addr_d     = m_addr[32'(sel_idx)*ADDR_W +: ADDR_W];
                    s_wdata_d    = m_wdata[32'(sel_idx)*DATA_W +: DATA_W];
                    // A master raising both strobes gets a write only.
                    s_write_en_d = m_write_en[sel_idx];
                    s_read_en_d  = m_read_en[sel_idx] & ~m_write_en[sel_idx];
                end
            end
            ISSUE: begin
                state_d  = IDLE;
                locked_d = m_lock[grant_idx_q];
                if (!m_lock[grant_idx_q]) begin
                    rr_ptr_d = (32'(grant_idx_q) == NUM_MASTERS - 1) ? '0
                                                                       : grant_idx_q + 1'b1;
                end
                if (s_read_en_q) begin
                    rdata_d  = s_rdata;
                    rvalid_d = owner_mask;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        m_ack      = (state_q == ISSUE) ? owner_mask : '0;
        m_rdata    = rdata_q;
        m_rvalid   = rvalid_q;
        s_addr     = s_addr_q;
        s_wdata    = s_wdata_q;
        s_read_en  = s_read_en_q;
        s_write_en = s_write_en_q;
        grant_idx  = grant_idx_q;
        locked     = locked_q;
    end

endmodule
